// File: rtl/uart_rx_if.sv
// Serial-line and parallel-result bundle for uart_rx.
// master drives the line and the tick; slave is the receiver.
interface uart_rx_if;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  modport master (output rx, s_tick, input dout, rx_done_tick, frame_err, parity_err);
  modport slave  (input rx, s_tick, output dout, rx_done_tick, frame_err, parity_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling on s_tick and a 2-FF input synchroniser.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [7:0]      b_q, b_d;
  logic [7:0]      dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic [1:0]      sync_q, sync_d;
  logic            rx_s;
  logic [7:0]      data_w;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  assign rx_s   = sync_q[1];
  assign data_w = b_q >> (8 - DBIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sync_q  <= 2'b11;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      sync_q  <= sync_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    sync_d  = {sync_q[0], bus.rx};
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      // Falling edge alone starts a frame; the tick grid is picked up in START.
      IDLE: if (!rx_s) begin
        state_d = START;
        s_d     = '0;
      end
      START: if (bus.s_tick) begin
        if (s_q == SW'(7)) begin
          s_d = '0;
          n_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else s_d = s_q + 1'b1;
      end
      DATA: if (bus.s_tick) begin
        if (s_q == SW'(15)) begin
          b_d = {rx_s, b_q[7:1]};
          s_d = '0;
          if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else n_d = n_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bus.s_tick) begin
        if (s_q == SW'(15)) begin
          par_d   = rx_s;
          s_d     = '0;
          state_d = STOP;
        end else s_d = s_q + 1'b1;
      end
`endif
      // A framing error still delivers the byte, flagged.
      STOP: if (bus.s_tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          state_d = IDLE;
          dout_d  = data_w;
          ferr_d  = ~rx_s;
          done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_d  = (^data_w) ^ par_q;
`endif
        end else s_d = s_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif
endmodule
